des128_round_ctrl: RTL and testbench

- Round sequencer for the 128-bit expanded DES core.
- Splits a 128-bit block into 64-bit L/R halves and drives R to the external round-function datapath (64->96 expansion, subkey XOR, S-boxes, P).
- Selects the subkey index, folds F results back into the Feistel state for ROUNDS rounds, and returns the 128-bit result over a valid/ready handshake.

---
 rtl/des128_round_ctrl.sv | 167 ++++++++++++++++
 tb/tb_des128_round_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des128_round_ctrl.sv
`timescale 1ns/1ps
// des128_round_ctrl
// Round sequencer for the 128-bit expanded DES core. A 128-bit block is split into 64-bit
// L/R halves. R is driven to an external round-function datapath together with a subkey
// index. The F result is folded back into the Feistel state for ROUNDS rounds, and the
// result is returned over a valid/ready handshake.
//
// Ports:
//   CLK        system clock; all state changes on the rising edge
//   RST        synchronous, active-high reset
//   IN_VALID   DATA_IN/MODE valid
//   IN_READY   controller can accept a block (combinational: state == IDLE)
//   DATA_IN    input block, [127:64] = L0, [63:0] = R0
//   MODE       0 = encrypt, 1 = decrypt; sampled on the input handshake
//   F_R        current right half, to the round function
//   KEY_IDX    subkey index for the current round
//   F_EN       one-cycle launch strobe for the round function
//   F_OUT      f(R, K) result from the round function
//   OUT_VALID  DATA_OUT valid
//   OUT_READY  consumer accepts DATA_OUT
//   DATA_OUT   result {R_final, L_final}; no swap after the last round
//   BUSY       high in RUN or OUT
//   ROUND      current round number, 0-based

module des128_round_ctrl #(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned F_LAT  = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] DATA_IN,
  input  logic         MODE,
  output logic [63:0]  F_R,
  output logic [3:0]   KEY_IDX,
  output logic         F_EN,
  input  logic [63:0]  F_OUT,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] DATA_OUT,
  output logic         BUSY,
  output logic [3:0]   ROUND
);

  // The round index and key index are 4 bits wide, and the latency counter is 3 bits wide.
  if (ROUNDS < 2 || ROUNDS > 16) begin : g_bad_rounds
    $error("des128_round_ctrl: ROUNDS must be in 2..16");
  end
  if (F_LAT > 7) begin : g_bad_lat
    $error("des128_round_ctrl: F_LAT must be in 0..7");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StOut
  } state_e;

  localparam logic [3:0] LastRound = 4'(ROUNDS - 1);
  localparam logic [2:0] LastCyc   = 3'(F_LAT);

  state_e        r_state;
  logic [63:0]   r_l;
  logic [63:0]   r_r;
  logic          r_mode;
  logic [3:0]    r_round;
  logic [2:0]    r_lat_cnt;
  logic [3:0]    r_key_idx;
  logic          r_f_en;
  logic          r_out_valid;
  logic [127:0]  r_data_out;
  logic          r_busy;

  logic          w_last_cyc;
  logic          w_last_round;
  logic [63:0]   w_new_r;
  logic [3:0]    w_next_round;
  logic [3:0]    w_next_key;
  logic [3:0]    w_first_key;

  always_comb begin
    w_last_cyc   = (r_lat_cnt == LastCyc);
    w_last_round = (r_round == LastRound);
    w_new_r      = r_l ^ F_OUT;
    w_next_round = r_round + 4'd1;
    // Decrypt walks the subkeys in reverse order.
    w_next_key   = r_mode ? (LastRound - w_next_round) : w_next_round;
    w_first_key  = MODE ? LastRound : 4'd0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StIdle;
      r_l         <= '0;
      r_r         <= '0;
      r_mode      <= 1'b0;
      r_round     <= '0;
      r_lat_cnt   <= '0;
      r_key_idx   <= '0;
      r_f_en      <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // IN_READY is high throughout IDLE, so IN_VALID alone completes the handshake.
          if (IN_VALID) begin
            r_l       <= DATA_IN[127:64];
            r_r       <= DATA_IN[63:0];
            r_mode    <= MODE;
            r_round   <= '0;
            r_lat_cnt <= '0;
            // Key and strobe must already be valid in the first RUN cycle.
            r_key_idx <= w_first_key;
            r_f_en    <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= StRun;
          end
        end
        StRun: begin
          if (w_last_cyc) begin
            r_l       <= r_r;
            r_r       <= w_new_r;
            r_lat_cnt <= '0;
            if (w_last_round) begin
              // The output swaps the halves back: {L ^ F, R} is {R_final, L_final}.
              r_data_out  <= {w_new_r, r_r};
              r_out_valid <= 1'b1;
              r_f_en      <= 1'b0;
              r_round     <= '0;
              r_state     <= StOut;
            end else begin
              r_round   <= w_next_round;
              r_key_idx <= w_next_key;
              r_f_en    <= 1'b1;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
            r_f_en    <= 1'b0;
          end
        end
        StOut: begin
          if (OUT_READY) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    IN_READY  = (r_state == StIdle);
    F_R       = r_r;
    KEY_IDX   = r_key_idx;
    F_EN      = r_f_en;
    OUT_VALID = r_out_valid;
    DATA_OUT  = r_data_out;
    BUSY      = r_busy;
    ROUND     = r_round;
  end

endmodule

// File: tb/tb_des128_round_ctrl.sv
`timescale 1ns/1ps
// Directed bench for des128_round_ctrl. There are two instances: one with a combinational
// round function (F_LAT=0) and one with a 2-cycle pipelined round function (F_LAT=2).
// sel routes the shared stimulus to one of the two instances and picks which outputs are
// observed.
module tb_des128_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sel       = 1'b0;
  logic         in_valid  = 1'b0;
  logic         mode_i    = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in   = '0;
  int           fsel      = 0;

  int n_vec  = 0;
  int n_fail = 0;

  logic         in_ready0, f_en0, out_valid0, busy0;
  logic [63:0]  f_r0, f_out0;
  logic [3:0]   key0, round0;
  logic [127:0] data_out0;
  logic         in_ready2, f_en2, out_valid2, busy2;
  logic [63:0]  f_r2, f_out2, p1, p2;
  logic [3:0]   key2, round2;
  logic [127:0] data_out2;

  logic         in_ready_s, f_en_s, out_valid_s, busy_s;
  logic [3:0]   key_idx_s, round_s;
  logic [127:0] data_out_s;

  function automatic logic [63:0] ffun(input int s, input logic [63:0] r, input logic [3:0] k);
    int sh;
    sh = 64 - int'(k);
    case (s)
      0:       return 64'h0;
      1:       return r ^ {60'h0, k};
      default: return ((r << k) | (r >> sh)) ^ 64'hA5A5A5A5A5A5A5A5;
    endcase
  endfunction

  // Reference Feistel network over 16 rounds, with no swap after the last round.
  function automatic logic [127:0] model(input logic [127:0] blk, input logic m, input int s);
    logic [63:0] l, r, t;
    logic [3:0]  k;
    l = blk[127:64];
    r = blk[63:0];
    for (int i = 0; i < 16; i++) begin
      k = m ? 4'(15 - i) : 4'(i);
      t = r;
      r = l ^ ffun(s, r, k);
      l = t;
    end
    return {r, l};
  endfunction

  assign f_out0 = ffun(fsel, f_r0, key0);
  always_ff @(posedge clk) begin
    p1 <= ffun(fsel, f_r2, key2);
    p2 <= p1;
  end
  assign f_out2 = p2;

  des128_round_ctrl #(.ROUNDS(16), .F_LAT(0)) u_dut0 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid & ~sel), .IN_READY(in_ready0),
    .DATA_IN(data_in), .MODE(mode_i), .F_R(f_r0), .KEY_IDX(key0), .F_EN(f_en0),
    .F_OUT(f_out0), .OUT_VALID(out_valid0), .OUT_READY(out_ready), .DATA_OUT(data_out0),
    .BUSY(busy0), .ROUND(round0)
  );

  des128_round_ctrl #(.ROUNDS(16), .F_LAT(2)) u_dut2 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid & sel), .IN_READY(in_ready2),
    .DATA_IN(data_in), .MODE(mode_i), .F_R(f_r2), .KEY_IDX(key2), .F_EN(f_en2),
    .F_OUT(f_out2), .OUT_VALID(out_valid2), .OUT_READY(out_ready), .DATA_OUT(data_out2),
    .BUSY(busy2), .ROUND(round2)
  );

  assign in_ready_s  = sel ? in_ready2  : in_ready0;
  assign f_en_s      = sel ? f_en2      : f_en0;
  assign out_valid_s = sel ? out_valid2 : out_valid0;
  assign busy_s      = sel ? busy2      : busy0;
  assign key_idx_s   = sel ? key2       : key0;
  assign round_s     = sel ? round2     : round0;
  assign data_out_s  = sel ? data_out2  : data_out0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pushes one block through the selected instance and checks latency, the F_EN pattern,
  // the KEY_IDX sequence and the result. It then optionally holds OUT_READY low for
  // `hold` cycles before completing the output handshake.
  task automatic run_block(input logic s, input logic [127:0] din, input logic m, input int lat,
                           input int hold, input logic [127:0] exp_out, input string tag,
                           output logic [127:0] dout);
    int e, fen, pat_err, key_err, stab_err;
    logic [3:0]   ek;
    logic [127:0] held;
    e = 0; fen = 0; pat_err = 0; key_err = 0; stab_err = 0;
    @(negedge clk);
    sel = s; in_valid = 1'b1; data_in = din; mode_i = m; out_ready = 1'b0;
    chk({tag, ".in_ready_idle"}, in_ready_s, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; data_in = ~din; mode_i = ~m;
    while (out_valid_s !== 1'b1 && e < 400) begin
      ek = m ? 4'(15 - e / (lat + 1)) : 4'(e / (lat + 1));
      if (f_en_s !== ((e % (lat + 1)) == 0)) pat_err++;
      if (f_en_s === 1'b1) fen++;
      if (key_idx_s !== ek) key_err++;
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    chk({tag, ".latency"}, e, 16 * (lat + 1));
    chk({tag, ".f_en_count"}, fen, 16);
    chk({tag, ".f_en_pattern_errs"}, pat_err, 0);
    chk({tag, ".key_idx_errs"}, key_err, 0);
    chk({tag, ".data_out"}, data_out_s, exp_out);
    chk({tag, ".busy_out"}, busy_s, 1);
    held = data_out_s;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom % 2);
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      mode_i   = 1'($urandom % 2);
      @(posedge clk);
      @(negedge clk);
      if (data_out_s !== held || out_valid_s !== 1'b1 || in_ready_s !== 1'b0 || busy_s !== 1'b1)
        stab_err++;
    end
    if (hold > 0) chk({tag, ".backpressure_errs"}, stab_err, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".out_valid_after_hs"}, out_valid_s, 0);
    chk({tag, ".in_ready_after_hs"}, in_ready_s, 1);
    chk({tag, ".busy_after_hs"}, busy_s, 0);
    chk({tag, ".data_out_kept"}, data_out_s, held);
    dout = held;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk, enc, dec, d;
    int           n, viol;
    int           acc[$];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", in_ready0, 1);
    chk("rst.busy", busy0, 0);
    chk("rst.out_valid", out_valid0, 0);
    chk("rst.data_out", data_out0, 0);
    chk("rst.round", round0, 0);
    chk("rst.key_idx", key0, 0);
    chk("rst.f_en", f_en0, 0);
    chk("rst.f_r", f_r0, 0);
    chk("rst2.out_valid", out_valid2, 0);
    chk("rst2.f_en", f_en2, 0);
    rst = 1'b0;

    // F = 0: 16 plain swaps bring the halves back, then the output swaps them.
    fsel = 0;
    run_block(1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 0, 0,
              128'hFEDCBA9876543210_0123456789ABCDEF, "zero_f", d);

    // Pipelined round function: F_OUT = F_R ^ KEY_IDX, 2 cycles late.
    fsel = 1;
    blk  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    run_block(1'b1, blk, 1'b0, 2, 0, model(blk, 1'b0, 1), "lat2", d);

    // Round trip: encrypt and then decrypt (both latencies).
    fsel = 2;
    blk  = 128'hDEADBEEFCAFEBABE_0011223344556677;
    run_block(1'b0, blk, 1'b0, 0, 0, model(blk, 1'b0, 2), "rt_enc", enc);
    run_block(1'b0, enc, 1'b1, 0, 0, blk, "rt_dec", dec);
    run_block(1'b1, enc, 1'b1, 2, 0, blk, "rt_dec_lat2", dec);

    // Backpressure for 5 cycles
    blk = 128'h1122334455667788_99AABBCCDDEEFF00;
    run_block(1'b0, blk, 1'b0, 0, 5, model(blk, 1'b0, 2), "bp", d);

    // Reset in the middle of round 7
    @(negedge clk);
    sel = 1'b0; in_valid = 1'b1; data_in = 128'hCAFEF00D_12345678_9ABCDEF0_0BADBEEF; mode_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (round_s !== 4'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midrst.reached_round7", round_s, 7);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.in_ready", in_ready_s, 1);
    chk("midrst.busy", busy_s, 0);
    chk("midrst.out_valid", out_valid_s, 0);
    chk("midrst.round", round_s, 0);
    chk("midrst.f_en", f_en_s, 0);
    blk = 128'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    run_block(1'b0, blk, 1'b0, 0, 0, model(blk, 1'b0, 2), "fresh", d);

    // IN_VALID held high with OUT_READY high: one accept every 18 cycles
    fsel = 0;
    @(negedge clk);
    sel = 1'b0; in_valid = 1'b1; out_ready = 1'b1; data_in = 128'h5;
    viol = 0;
    for (int c = 0; c < 60; c++) begin
      if (in_ready_s === 1'b1) acc.push_back(c);
      if (busy_s === 1'b1 && in_ready_s === 1'b1) viol++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream.accepts", acc.size(), 4);
    if (acc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("stream.spacing", acc[i] - acc[i-1], 18);
    end
    chk("stream.busy_accept_overlap", viol, 0);
    n = 0;
    while (in_ready_s !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("stream.drained", in_ready_s, 1);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
